// File: rtl/atu_pkg.sv
// Shared types and constants for the external ATU tune scheduler.
package atu_pkg;

    localparam int TMR_W = 16;
    typedef logic [TMR_W-1:0] tmr_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_BUSY = 3'd3;
    localparam logic [2:0] ST_REL  = 3'd4;
    localparam logic [2:0] ST_COOL = 3'd5;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_NORESP  = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd2;
    localparam logic [1:0] FAIL_ABORT   = 2'd3;

    localparam logic [1:0] SRC_HOST = 2'd0;
    localparam logic [1:0] SRC_KEY  = 2'd1;
    localparam logic [1:0] SRC_BAND = 2'd2;

    function automatic tmr_t ms_load(input int ms);
        return tmr_t'(ms - 1);
    endfunction

endpackage

// File: rtl/atu_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module atu_tick_gen #(
    parameter int TICK_DIV = 76800
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/atu_tune_scheduler.sv
// Arbitrates tune requests and sequences one ATU tune session at a time,
// with no-response retries and a cooldown between attempts.
module atu_tune_scheduler
    import atu_pkg::*;
#(
    parameter int TICK_DIV      = 76800,
    parameter int RESP_LIMIT_MS = 1700,
    parameter int TUNE_LIMIT_MS = 9000,
    parameter int COOLDOWN_MS   = 250,
    parameter int MAX_RETRY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_host,
    input  logic       req_key,
    input  logic [3:0] band,
    input  logic       band_valid,
    input  logic       retune_en,
    input  logic       abort,
    input  logic       atu_status,
    output logic       tune_auto,
    output logic       tune_tx_req,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic [1:0] fail_code,
    output logic [1:0] last_src,
    output logic [1:0] attempt
);

    localparam tmr_t RESP_LD = ms_load(RESP_LIMIT_MS);
    localparam tmr_t TUNE_LD = ms_load(TUNE_LIMIT_MS);
    localparam tmr_t COOL_LD = ms_load(COOLDOWN_MS);

    logic       tick;
    logic [2:0] st_q, st_d;
    tmr_t       tmr_q, tmr_d;
    logic       host_q;
    logic [2:0] pend_q, pend_d;
    logic [3:0] sband_q, sband_d;
    logic       seen_q, seen_d;
    logic       retry_q, retry_d;
    logic       ok_q, ok_d;
    logic [1:0] fail_q, fail_d;
    logic [1:0] src_q, src_d;
    logic [1:0] att_q, att_d;
    logic [2:0] pset;
    logic       expire;
    logic       go_rel;
    logic [1:0] rel_code;

    atu_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .tick_o(tick)
    );

    // pend bit order: [2]=key, [1]=host, [0]=band
    assign pset[2] = req_key;
    assign pset[1] = req_host & ~host_q;
    assign pset[0] = band_valid & retune_en & seen_q
                   & (band != sband_q);

    assign expire = tick & (tmr_q == '0);

    always_comb begin
        st_d     = st_q;
        tmr_d    = (tick && tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
        pend_d   = pend_q | pset;
        sband_d  = band_valid ? band : sband_q;
        seen_d   = seen_q | band_valid;
        retry_d  = retry_q;
        ok_d     = ok_q;
        fail_d   = fail_q;
        src_d    = src_q;
        att_d    = att_q;
        go_rel   = 1'b0;
        rel_code = FAIL_NONE;
        case (st_q)
            ST_IDLE: begin
                if (abort) begin
                    pend_d = '0;
                end else if (pend_q != '0) begin
                    // new arrivals in the grant cycle survive the clear
                    pend_d  = pset;
                    src_d   = pend_q[2] ? SRC_KEY :
                              pend_q[1] ? SRC_HOST : SRC_BAND;
                    att_d   = '0;
                    ok_d    = 1'b0;
                    fail_d  = FAIL_NONE;
                    retry_d = 1'b0;
                    st_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    go_rel   = 1'b1;
                    rel_code = FAIL_ABORT;
                end else begin
                    tmr_d = RESP_LD;
                    st_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    go_rel   = 1'b1;
                    rel_code = FAIL_ABORT;
                end else if (atu_status) begin
                    tmr_d = TUNE_LD;
                    st_d  = ST_BUSY;
                end else if (expire) begin
                    go_rel   = 1'b1;
                    rel_code = FAIL_NORESP;
                end
            end
            ST_BUSY: begin
                if (abort) begin
                    go_rel   = 1'b1;
                    rel_code = FAIL_ABORT;
                end else if (!atu_status) begin
                    go_rel   = 1'b1;
                    rel_code = FAIL_NONE;
                end else if (expire) begin
                    go_rel   = 1'b1;
                    rel_code = FAIL_TIMEOUT;
                end
            end
            ST_REL: begin
                tmr_d = COOL_LD;
                st_d  = ST_COOL;
                if (retry_q) begin
                    att_d = att_q + 2'd1;
                end
            end
            ST_COOL: begin
                if (abort) begin
                    pend_d = '0;
                end
                if (expire) begin
                    st_d = retry_q ? ST_ARM : ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        // the outcome is latched on entry so it is valid alongside done
        if (go_rel) begin
            st_d    = ST_REL;
            retry_d = (rel_code == FAIL_NORESP)
                    && (att_q < 2'(MAX_RETRY));
            if (!retry_d) begin
                ok_d   = (rel_code == FAIL_NONE);
                fail_d = rel_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            tmr_q   <= '0;
            host_q  <= 1'b0;
            pend_q  <= '0;
            sband_q <= '0;
            seen_q  <= 1'b0;
            retry_q <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= FAIL_NONE;
            src_q   <= SRC_HOST;
            att_q   <= '0;
        end else begin
            st_q    <= st_d;
            tmr_q   <= tmr_d;
            host_q  <= req_host;
            pend_q  <= pend_d;
            sband_q <= sband_d;
            seen_q  <= seen_d;
            retry_q <= retry_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            src_q   <= src_d;
            att_q   <= att_d;
        end
    end

    assign tune_auto   = (st_q == ST_ARM) || (st_q == ST_WAIT)
                       || (st_q == ST_BUSY);
    assign tune_tx_req = tune_auto;
    assign busy        = tune_auto || (st_q == ST_REL)
                       || ((st_q == ST_COOL) && retry_q);
    assign done        = (st_q == ST_REL) && !retry_q;
    assign ok          = ok_q;
    assign fail_code   = fail_q;
    assign last_src    = src_q;
    assign attempt     = att_q;

endmodule

// File: doc/atu_tune_scheduler.md
Name: atu_tune_scheduler

Overview:
Schedules external-ATU (AH-4 style) tune sessions for the Hermes-Lite v2 gateware. It accepts tune requests from three sources: a host command bit, the front-panel key, and a band change. It grants one session at a time and drives the tuner controller's auto_tune input plus a carrier request to the TX path. It watches the ATU status line to classify the outcome, retries sessions where the ATU gave no response, and enforces a cooldown between sessions.

Parameters:
TICK_DIV, 76800, clk cycles per 1 ms tick (76.8 MHz clk).
RESP_LIMIT_MS, 1700, ms from auto_tune assertion to atu_status high before "no response".
TUNE_LIMIT_MS, 9000, ms max atu_status high before "tune timeout".
COOLDOWN_MS, 250, ms auto_tune held low between sessions or attempts.
MAX_RETRY, 2, extra attempts after a no-response failure.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
req_host  in  1  host tune command, level; rising edge is a request
req_key  in  1  front-panel tune key, single-cycle pulse, already debounced
band  in  4  current TX band index
band_valid  in  1  band sample strobe
retune_en  in  1  enables band-change requests
abort  in  1  single-cycle abort from host/PTT logic
atu_status  in  1  ATU busy line (already synchronised upstream)
tune_auto  out  1  drives tuner controller auto_tune
tune_tx_req  out  1  request low-power carrier during session
busy  out  1  session in progress (ARM..RELEASE)
done  out  1  one-cycle pulse at session end
ok  out  1  last session succeeded (held until next grant)
fail_code  out  2  0 none, 1 no response, 2 tune timeout, 3 aborted
last_src  out  2  0 host, 1 key, 2 band, latched at grant
attempt  out  2  current/last attempt number, 0-based

Behaviour:
- Reset: every output 0. State IDLE, pending bits clear, prescaler 0. stored_band = 0, band_seen = 0.
- Reset mid-session: immediate return to reset state. tune_auto drops the cycle after rst samples high. No done pulse.
- Tick: internal prescaler pulses tick every TICK_DIV cycles. All timers are 16-bit, load LIMIT-1, decrement on tick, and expire when 0 on a tick.
- Request capture (any cycle):
  - host_pend is set on req_host rising edge.
  - key_pend is set on req_key.
  - band_pend is set on band_valid when retune_en=1, band_seen=1 and band != stored_band.
  - Every band_valid updates stored_band and sets band_seen. The first band_valid after reset never requests.
- Grant (IDLE, any cycle, any pend set):
  - Priority key > host > band.
  - Clear all pend bits; one tune covers all pending requests.
  - Set last_src, attempt=0, ok=0, fail_code=0; enter ARM.
- Requests arriving while busy or in COOLDOWN: set pend bits, served after COOLDOWN.
- States:
  - IDLE: tune_auto=0, tune_tx_req=0.
  - ARM: tune_auto=1, tune_tx_req=1, load RESP timer → WAIT_RESP next cycle.
  - WAIT_RESP: atu_status=1 → load TUNE timer, go to BUSY. Timer expiry → RELEASE with fail 1.
  - BUSY: atu_status=0 → RELEASE with ok. Timer expiry → RELEASE with fail 2.
  - RELEASE (one cycle): tune_auto=0, tune_tx_req=0, load COOLDOWN timer.
    - If fail 1 and attempt<MAX_RETRY: attempt+1, go to COOLDOWN, then ARM; no done pulse.
    - Otherwise: pulse done, latch ok/fail_code, go to COOLDOWN, then IDLE.
  - COOLDOWN: outputs low until timer expiry.
- busy=1 in ARM, WAIT_RESP, BUSY and RELEASE, including retry cooldowns (busy stays 1 across retry gaps).
- abort in ARM/WAIT_RESP/BUSY: next cycle RELEASE with fail 3. No retry.
- abort in IDLE/COOLDOWN: clears all pend bits.
- Simultaneous abort and atu_status fall in BUSY: abort wins (fail 3).
- Simultaneous grant and abort in IDLE: abort wins, no grant.
- ok and fail_code are mutually exclusive; they change only at RELEASE-final or grant.

Decomposition:
- Package atu_pkg holds:
  - state enum (IDLE, ARM, WAIT_RESP, BUSY, RELEASE, COOLDOWN);
  - fail codes FAIL_NONE/NORESP/TIMEOUT/ABORT;
  - source codes SRC_HOST/KEY/BAND;
  - the 16-bit timer width.
- One sub-module: atu_tick_gen (prescaler, parameter TICK_DIV, output tick).

Test Plan:
- TICK_DIV=4, key pulse; atu_status rises 10 ms after tune_auto and falls 50 ms later → tune_auto high about 60 ticks, done pulse, ok=1, fail_code=0, last_src=1.
- atu_status held 0, MAX_RETRY=2 → exactly 3 tune_auto assertions separated by COOLDOWN_MS; final done with fail_code=1, attempt=2; no done on the first two attempts.
- atu_status rises and never falls → release after TUNE_LIMIT_MS ticks, fail_code=2, no retry.
- req_key and req_host rising in the same cycle, plus band change 3→5 with retune_en=1 → single session with last_src=1; no second session afterwards.
- abort during BUSY coincident with atu_status fall → fail_code=3, tune_auto=0 next cycle. Repeat with rst mid-WAIT_RESP → all outputs 0, no done.
- Band change during BUSY → second session granted after COOLDOWN with last_src=2. First band_valid after reset → no request.
